// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: register-select type and pipeline sequencer states.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        MEMWAIT = 2'd2,
        HALT    = 2'd3
    } pipe_state_t;

endpackage

// File: rtl/pipeline_sequencer_load_use_detect.sv
// Load-use hazard detection: a load in EX whose destination feeds an ID-stage source.
module load_use_detect #(
    parameter int REG_W = 5
) (
    input  logic             ex_dREN,
    input  logic [REG_W-1:0] ex_wsel,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             lu_hazard
);

    // Register zero is hardwired, so a load targeting it never creates a dependency.
    assign lu_hazard = ex_dREN && (ex_wsel != '0) &&
                       ((ex_wsel == id_rs) || (ex_wsel == id_rt));

endmodule

// File: rtl/pipeline_sequencer.sv
// Stall/flush controller for the pipeline register bank, with saturating
// stall-cycle and redirect-event performance counters.
module pipeline_sequencer
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int REG_W = $bits(regbits_t)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             mem_redirect,
    input  logic             ex_dREN,
    input  logic [REG_W-1:0] ex_wsel,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             en_ifid,
    output logic             en_idex,
    output logic             en_exmem,
    output logic             en_memwb,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    pipe_state_t state, state_n;
    logic        lu_hazard;
    logic        issue;
    logic        in_flow;
    logic        stall_evt;
    logic        flush_evt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    load_use_detect #(.REG_W(REG_W)) u_lu (
        .ex_dREN   (ex_dREN),
        .ex_wsel   (ex_wsel),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .lu_hazard (lu_hazard)
    );

    // State transition plus priority decode of enables/flushes; 'issue' marks
    // a cycle where the pipe may advance subject to redirect/hazard/imiss rules.
    always_comb begin
        state_n     = state;
        issue       = 1'b0;
        pc_en       = 1'b0;
        en_ifid     = 1'b0;
        en_idex     = 1'b0;
        en_exmem    = 1'b0;
        en_memwb    = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        halted      = 1'b0;
        case (state)
            IDLE: state_n = RUN;
            RUN: begin
                if (wb_halt) begin
                    halted  = 1'b1;
                    state_n = HALT;
                end else if ((mem_dREN || mem_dWEN) && !dhit) begin
                    state_n = MEMWAIT;
                end else begin
                    issue = 1'b1;
                end
            end
            MEMWAIT: begin
                if (wb_halt) begin
                    halted  = 1'b1;
                    state_n = HALT;
                end else if (dhit) begin
                    issue   = 1'b1;
                    state_n = RUN;
                end
            end
            HALT: halted = 1'b1;
            default: state_n = IDLE;
        endcase

        if (issue) begin
            if (mem_redirect) begin
                // Wrong-path instructions in IF/ID/EX are squashed as the target loads.
                pc_en       = 1'b1;
                en_ifid     = 1'b1;
                en_idex     = 1'b1;
                en_exmem    = 1'b1;
                en_memwb    = 1'b1;
                flush_ifid  = 1'b1;
                flush_idex  = 1'b1;
                flush_exmem = 1'b1;
            end else if (lu_hazard || !ihit) begin
                // Hold fetch/decode and inject one bubble into EX.
                en_idex     = 1'b1;
                flush_idex  = 1'b1;
                en_exmem    = 1'b1;
                en_memwb    = 1'b1;
            end else begin
                pc_en       = 1'b1;
                en_ifid     = 1'b1;
                en_idex     = 1'b1;
                en_exmem    = 1'b1;
                en_memwb    = 1'b1;
            end
        end
    end

    assign in_flow   = (state == RUN) || (state == MEMWAIT);
    assign stall_evt = in_flow && (!pc_en || flush_ifid || flush_idex || flush_exmem);
    assign flush_evt = issue && mem_redirect;

    // FSM state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_n;
    end

    // Saturating performance counters; they only move while the pipe is flowing.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt) stall_cnt <= sat_inc(stall_cnt);
            if (flush_evt) flush_cnt <= sat_inc(flush_cnt);
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Randomized bench for pipeline_sequencer against a behavioural model of the
// stall/flush rules; narrow counters so saturation is reachable quickly.
module tb_pipeline_sequencer;

    localparam int CNT_W = 4;
    localparam int REG_W = 5;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             ihit, dhit, mem_dREN, mem_dWEN, mem_redirect, ex_dREN, wb_halt;
    logic [REG_W-1:0] ex_wsel, id_rs, id_rt;
    logic             pc_en, en_ifid, en_idex, en_exmem, en_memwb;
    logic             flush_ifid, flush_idex, flush_exmem, halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [8:0]       dut_ctl;

    int n_cmp = 0;
    int n_mis = 0;

    // Model: mode 0 idle, 1 running, 2 waiting on data memory, 3 halted.
    int         m_mode;
    int         m_stall;
    int         m_flush;
    logic [8:0] m_ctl;
    int         m_mode_n;
    bit         m_redir;
    int         halt_age;

    localparam logic [8:0] C_ZERO   = 9'b00000_000_0;
    localparam logic [8:0] C_HALT   = 9'b00000_000_1;
    localparam logic [8:0] C_FLOW   = 9'b11111_000_0;
    localparam logic [8:0] C_BUBBLE = 9'b00111_010_0;
    localparam logic [8:0] C_REDIR  = 9'b11111_111_0;

    always #5 CLK = ~CLK;

    pipeline_sequencer #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .ihit         (ihit),
        .dhit         (dhit),
        .mem_dREN     (mem_dREN),
        .mem_dWEN     (mem_dWEN),
        .mem_redirect (mem_redirect),
        .ex_dREN      (ex_dREN),
        .ex_wsel      (ex_wsel),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .wb_halt      (wb_halt),
        .pc_en        (pc_en),
        .en_ifid      (en_ifid),
        .en_idex      (en_idex),
        .en_exmem     (en_exmem),
        .en_memwb     (en_memwb),
        .flush_ifid   (flush_ifid),
        .flush_idex   (flush_idex),
        .flush_exmem  (flush_exmem),
        .halted       (halted),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    assign dut_ctl = {pc_en, en_ifid, en_idex, en_exmem, en_memwb,
                      flush_ifid, flush_idex, flush_exmem, halted};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs and next mode from the current inputs, straight from the rules.
    task automatic model_eval();
        bit lu, busy, dmiss;
        lu    = ex_dREN && (ex_wsel != 0) && ((ex_wsel == id_rs) || (ex_wsel == id_rt));
        dmiss = (mem_dREN || mem_dWEN) && !dhit;
        busy  = (m_mode == 1) ? dmiss : !dhit;
        m_ctl    = C_ZERO;
        m_mode_n = m_mode;
        m_redir  = 0;
        if (m_mode == 0) begin
            m_mode_n = 1;
        end else if (m_mode == 3) begin
            m_ctl = C_HALT;
        end else if (wb_halt) begin
            m_ctl    = C_HALT;
            m_mode_n = 3;
        end else if (busy) begin
            m_mode_n = 2;
        end else begin
            m_mode_n = 1;
            if (mem_redirect) begin
                m_ctl   = C_REDIR;
                m_redir = 1;
            end else if (lu || !ihit) begin
                m_ctl = C_BUBBLE;
            end else begin
                m_ctl = C_FLOW;
            end
        end
    endtask

    task automatic set_quiet();
        ihit = 1; dhit = 0; mem_dREN = 0; mem_dWEN = 0; mem_redirect = 0;
        ex_dREN = 0; ex_wsel = 0; id_rs = 0; id_rt = 0; wb_halt = 0;
    endtask

    // Inputs are already applied; check outputs mid-cycle, clock, then check counters.
    task automatic cycle();
        bit stalled;
        #1;
        model_eval();
        check_val("ctl", 32'(dut_ctl), 32'(m_ctl));
        stalled = (m_mode == 1 || m_mode == 2) && (!m_ctl[8] || (|m_ctl[3:1]));
        @(posedge CLK);
        if (stalled && m_stall < CMAX) m_stall++;
        if (m_redir && m_flush < CMAX) m_flush++;
        m_mode = m_mode_n;
        #1;
        check_val("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        check_val("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    endtask

    // Asynchronous reset asserted between edges and checked before any clock edge.
    task automatic do_reset();
        nRST = 0;
        #3;
        m_mode = 0; m_stall = 0; m_flush = 0;
        check_val("rst_ctl", 32'(dut_ctl), 32'(C_ZERO));
        check_val("rst_stall", 32'(stall_cnt), 32'd0);
        check_val("rst_flush", 32'(flush_cnt), 32'd0);
        @(negedge CLK);
        nRST = 1;
    endtask

    initial begin
        nRST = 1;
        set_quiet();
        @(posedge CLK);
        #1;

        // 1: plain flow after reset
        do_reset();
        set_quiet();
        repeat (5) cycle();
        check_val("t1_flow", 32'(dut_ctl), 32'(C_FLOW));
        check_val("t1_stall", 32'(stall_cnt), 32'd0);

        // 2: data-memory miss for three cycles
        do_reset();
        set_quiet();
        cycle();
        mem_dREN = 1; dhit = 0;
        repeat (3) cycle();
        dhit = 1;
        cycle();
        mem_dREN = 0; dhit = 0;
        check_val("t2_stall", 32'(stall_cnt), 32'd3);

        // 3: load-use bubble, then register zero never hazards
        do_reset();
        set_quiet();
        cycle();
        ex_dREN = 1; ex_wsel = 5'd8; id_rt = 5'd8; id_rs = 5'd3;
        #1;
        check_val("t3_bubble", 32'(dut_ctl), 32'(C_BUBBLE));
        cycle();
        ex_wsel = 5'd0; id_rt = 5'd0;
        #1;
        check_val("t3_r0", 32'(dut_ctl), 32'(C_FLOW));
        cycle();
        set_quiet();

        // 4: redirect beats load-use and imiss
        do_reset();
        set_quiet();
        cycle();
        mem_redirect = 1; ex_dREN = 1; ex_wsel = 5'd4; id_rs = 5'd4; ihit = 0;
        cycle();
        set_quiet();
        check_val("t4_flush", 32'(flush_cnt), 32'd1);

        // 5: halt beats a pending store miss, then reset recovers
        do_reset();
        set_quiet();
        cycle();
        wb_halt = 1; mem_dWEN = 1; dhit = 0;
        cycle();
        wb_halt = 0;
        repeat (10) cycle();
        check_val("t5_halt", 32'(dut_ctl), 32'(C_HALT));
        do_reset();
        set_quiet();
        cycle();
        check_val("t5_run", 32'(dut_ctl), 32'(C_FLOW));

        // 6: counter saturation
        do_reset();
        set_quiet();
        cycle();
        ihit = 0;
        repeat (20) cycle();
        check_val("t6_stall_sat", 32'(stall_cnt), 32'(CMAX));
        ihit = 1; mem_redirect = 1;
        repeat (20) cycle();
        check_val("t6_flush_sat", 32'(flush_cnt), 32'(CMAX));
        set_quiet();

        // Random traffic
        do_reset();
        halt_age = 0;
        for (int i = 0; i < 2000; i++) begin
            ihit         = ($urandom_range(99, 0) < 80);
            dhit         = ($urandom_range(99, 0) < 50);
            mem_dREN     = ($urandom_range(99, 0) < 20);
            mem_dWEN     = ($urandom_range(99, 0) < 10);
            mem_redirect = ($urandom_range(99, 0) < 15);
            wb_halt      = ($urandom_range(99, 0) < 2);
            ex_dREN      = ($urandom_range(99, 0) < 40);
            ex_wsel      = 5'($urandom_range(3, 0));
            id_rs        = 5'($urandom_range(3, 0));
            id_rt        = 5'($urandom_range(3, 0));
            if (m_mode == 3) halt_age++;
            if (halt_age > 8 || $urandom_range(63, 0) == 0) begin
                halt_age = 0;
                do_reset();
            end else begin
                cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
